uart_rx_top: RTL and testbench
==============================

# uart_rx_top

Parameterised UART receiver and the receive-side counterpart of the transmitter in the same design. It oversamples the serial line, recovers frames of start bit, DATA_WIDTH data bits LSB-first, optional parity and one stop bit, and presents the result as a one-cycle parallel word. Parity and stop-bit errors are flagged. It sits between the pad-side RX line and the parallel consumer logic.

## Interface
- DATA_WIDTH, 8, data bits per frame.
- OVERSAMPLE, 8, CLK cycles per bit; even, >= 4.
- CLK  input  1  sole clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- RX_IN  input  1  serial line, idle high, asynchronous to CLK.
- PARITY_ENABLE  input  1  1: frame carries a parity bit after the data.
- PARITY_TYPE  input  1  0: even, 1: odd (same convention as the transmitter).
- P_DATA  output  DATA_WIDTH  last good word; reset 0.
- DATA_VALID  output  1  one-cycle pulse when P_DATA is updated; reset 0.
- PARITY_ERROR  output  1  one-cycle pulse on parity mismatch; reset 0.
- STOP_ERROR  output  1  one-cycle pulse when the stop bit is sampled as 0; reset 0.

## Operation
- RX_IN passes through a 2-flop synchroniser, whose flops reset to 1. Every use of "line" below means the synchronised line.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: line == 0 moves to START. The first low cycle counts as cycle 0 of the start bit.
  - START: at the sample point, line == 1 is a glitch and returns to IDLE with no flags. Otherwise go to DATA.
  - DATA: take DATA_WIDTH samples, shifted in LSB-first. After the last one go to PARITY if PARITY_ENABLE = 1, else to STOP.
  - PARITY: compare the sample with the XOR of the data, inverted when PARITY_TYPE = 1. A mismatch sets the internal flag par_bad.
  - STOP: at the sample point, evaluate the frame and return to IDLE in the same cycle. The rest of the stop bit is not waited for, so a following start edge can be caught immediately.
- Stop evaluation, one cycle after the stop sample:
  - Sample 0: STOP_ERROR = 1.
  - par_bad set: PARITY_ERROR = 1.
  - Neither error: DATA_VALID = 1 and P_DATA is loaded.
  - Either error: P_DATA is left unchanged and DATA_VALID stays 0. Both error flags can pulse together.
- PARITY_ENABLE and PARITY_TYPE are latched on the IDLE->START transition. Changes during a frame are ignored.
- The bit counter is log2(DATA_WIDTH)+1 bits wide. The sample counter is log2(OVERSAMPLE) bits wide and wraps at OVERSAMPLE-1.

## Timing
- Sample point for bit k (start bit is k = 0) is cycle s + k*OVERSAMPLE + OVERSAMPLE/2 - 1, where s is the start-detect cycle.
- DATA_VALID / error flags are asserted at stop sample + 1.
- Example, DATA_WIDTH = 8, OVERSAMPLE = 8, no parity: stop sample at s+75, DATA_VALID at s+76.
- End-to-end latency from the raw RX_IN falling edge adds 2 cycles for the synchroniser.
- RST mid-frame: the next cycle is IDLE, all outputs 0, synchroniser 1. The partial frame is discarded without any flag.
- Tolerates up to roughly ±(OVERSAMPLE/2-1)/OVERSAMPLE of a bit of accumulated drift at the stop bit.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - Each bit takes three samples, at sample point -1, 0 and +1, and uses the 2-of-3 majority.
  - The decision is made at sample point +1, so every sample time and every output pulse moves one cycle later (example above: DATA_VALID at s+77).
  - The glitch check in START uses the majority value.
- Not defined: a single sample at the sample point; timing exactly as above.

## Test plan
- OVERSAMPLE = 8, no parity, send 0xA5 -> DATA_VALID pulse at s+76 with P_DATA = 0xA5; no error flags.
- PARITY_ENABLE = 1, PARITY_TYPE = 0, send 0x3C with parity bit 0 -> DATA_VALID, P_DATA = 0x3C. Same frame with parity bit 1 -> PARITY_ERROR pulse only, P_DATA keeps its old value.
- Send 0x81 with the stop bit forced to 0 -> STOP_ERROR pulse, no DATA_VALID.
- 2-cycle low glitch on an idle line -> FSM back in IDLE, no output pulses. Then send 0x55 -> received correctly.
- Two back-to-back frames, 0x12 then 0x34, with no idle gap -> two DATA_VALID pulses exactly 10*OVERSAMPLE cycles apart, carrying 0x12 and 0x34.
- RST asserted for 1 cycle in the middle of the data bits of 0xFF, then 0x0F sent -> no pulse for the aborted frame; DATA_VALID with P_DATA = 0x0F.

Source files
------------

// File: rtl/uart_rx_top.sv
// uart_rx_top -- oversampling UART receiver.
//
// Recovers frames of: start bit, DATA_WIDTH data bits (LSB first), optional
// parity bit, one stop bit. A good frame updates P_DATA with a one-cycle
// DATA_VALID pulse; parity and stop-bit problems pulse PARITY_ERROR /
// STOP_ERROR instead and leave P_DATA untouched.
//
// Parameters:
//   DATA_WIDTH    data bits per frame
//   OVERSAMPLE    CLK cycles per bit (even, >= 4)
// Ports:
//   CLK           sole clock, rising edge
//   RST           synchronous active-high reset
//   RX_IN         raw serial line, idle high, asynchronous to CLK
//   PARITY_ENABLE frame carries a parity bit (latched at start of frame)
//   PARITY_TYPE   0 = even, 1 = odd (latched at start of frame)
//   P_DATA        last good word
//   DATA_VALID    one-cycle pulse when P_DATA is updated
//   PARITY_ERROR  one-cycle pulse on parity mismatch
//   STOP_ERROR    one-cycle pulse when the stop bit reads 0
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   When defined, every bit is a 2-of-3 vote over the samples at sample
//   point -1, 0 and +1, decided at sample point +1 (all timing one cycle later).

module uart_rx_top #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PARITY_ENABLE,
    input  logic                  PARITY_TYPE,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PARITY_ERROR,
    output logic                  STOP_ERROR
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

`ifdef UART_RX_MAJORITY_EN
    // Vote completes one cycle after the nominal mid-bit sample.
    localparam logic [CNT_W-1:0] DECIDE_AT = CNT_W'(OVERSAMPLE / 2);
`else
    localparam logic [CNT_W-1:0] DECIDE_AT = CNT_W'(OVERSAMPLE / 2 - 1);
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Expected parity bit for a data word: even -> XOR of data, odd -> inverted.
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data,
                                        input logic                  odd);
        return (^data) ^ odd;
    endfunction

    // 2-of-3 majority vote.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    sync1_r;
    logic                    line_r;
    logic                    sample_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [BIT_W-1:0]        bit_cnt_r;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic                    pen_r;
    logic                    ptype_r;
    logic                    par_bad_r;
    logic                    at_sample_s;
    logic                    start_s;
    logic                    shift_s;
    logic                    par_chk_s;
    logic                    stop_eval_s;
    logic [DATA_WIDTH-1:0]   p_data_r;
    logic                    data_valid_r;
    logic                    parity_error_r;
    logic                    stop_error_r;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_r <= 1'b1;
            line_r  <= 1'b1;
        end else begin
            sync1_r <= RX_IN;
            line_r  <= sync1_r;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_r;

    // Holds the line values of the two previous cycles for the three-point vote.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hist_r <= 2'b11;
        end else begin
            hist_r <= {hist_r[0], line_r};
        end
    end

    assign sample_s = majority3(hist_r[1], hist_r[0], line_r);
`else
    assign sample_s = line_r;
`endif

    assign at_sample_s = (cnt_r == DECIDE_AT);

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and per-sample strobes.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        shift_s      = 1'b0;
        par_chk_s    = 1'b0;
        stop_eval_s  = 1'b0;
        case (state_r)
            IDLE: begin
                // IDLE looks at the raw synchronised line, not the vote.
                if (!line_r) begin
                    state_next_s = START;
                    start_s      = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (at_sample_s) begin
                    if (sample_s) begin
                        state_next_s = IDLE;   // glitch, not a start bit
                    end else begin
                        state_next_s = DATA;
                    end
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (at_sample_s) begin
                    shift_s = 1'b1;
                    if (bit_cnt_r == BIT_LAST) begin
                        if (pen_r) begin
                            state_next_s = PARITY;
                        end else begin
                            state_next_s = STOP;
                        end
                    end else begin
                        state_next_s = DATA;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
            PARITY: begin
                if (at_sample_s) begin
                    par_chk_s    = 1'b1;
                    state_next_s = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
            STOP: begin
                // Leave right at the sample so a following start edge is caught.
                if (at_sample_s) begin
                    stop_eval_s  = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Sample counter: the start-detect cycle is cycle 0 of the start bit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r <= CNT_ZERO;
        end else if (start_s) begin
            cnt_r <= CNT_ONE;
        end else if (state_r == IDLE) begin
            cnt_r <= CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Per-frame state: bit count, data shifter, latched config, parity flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt_r <= BIT_ZERO;
            shift_r   <= {DATA_WIDTH{1'b0}};
            pen_r     <= 1'b0;
            ptype_r   <= 1'b0;
            par_bad_r <= 1'b0;
        end else if (start_s) begin
            bit_cnt_r <= BIT_ZERO;
            pen_r     <= PARITY_ENABLE;
            ptype_r   <= PARITY_TYPE;
            par_bad_r <= 1'b0;
        end else if (shift_s) begin
            bit_cnt_r <= bit_cnt_r + BIT_ONE;
            shift_r   <= {sample_s, shift_r[DATA_WIDTH-1:1]};   // LSB arrives first
        end else if (par_chk_s) begin
            par_bad_r <= (sample_s != parity_bit(shift_r, ptype_r));
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Registered result pulses, produced one cycle after the stop sample.
    always_ff @(posedge CLK) begin
        if (RST) begin
            p_data_r       <= {DATA_WIDTH{1'b0}};
            data_valid_r   <= 1'b0;
            parity_error_r <= 1'b0;
            stop_error_r   <= 1'b0;
        end else begin
            data_valid_r   <= stop_eval_s & sample_s & ~par_bad_r;
            parity_error_r <= stop_eval_s & par_bad_r;
            stop_error_r   <= stop_eval_s & ~sample_s;
            if (stop_eval_s & sample_s & ~par_bad_r) begin
                p_data_r <= shift_r;
            end else begin
                p_data_r <= p_data_r;
            end
        end
    end

    assign P_DATA       = p_data_r;
    assign DATA_VALID   = data_valid_r;
    assign PARITY_ERROR = parity_error_r;
    assign STOP_ERROR   = stop_error_r;

endmodule

// File: tb/tb_uart_rx_top.sv
// Testbench for uart_rx_top. Frames are generated bit by bit from a
// description (data, parity setting, injected faults); the expected outcome
// and its cycle are computed from the frame rules and compared every cycle.
module tb_uart_rx_top;

    localparam int DW = 8;
    localparam int OS = 8;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic          pen;
    logic          ptype;
    logic [DW-1:0] p_data;
    logic          dv;
    logic          perr;
    logic          serr;

    uart_rx_top #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .CLK           (clk),
        .RST           (rst),
        .RX_IN         (rx_in),
        .PARITY_ENABLE (pen),
        .PARITY_TYPE   (ptype),
        .P_DATA        (p_data),
        .DATA_VALID    (dv),
        .PARITY_ERROR  (perr),
        .STOP_ERROR    (serr)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_q = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    typedef struct {
        int            at;
        logic          dv;
        logic          pe;
        logic          se;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    bit            chk_on = 1'b0;
    logic [DW-1:0] model_pdata = '0;
    logic          e_dv, e_pe, e_se;
    int            dv_cyc_q[$];
    logic [DW-1:0] dv_dat_q[$];
    int            pe_seen = 0;

    task automatic check_val(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
        end
    endtask

    // Per-cycle compare against the frame-level expectations.
    always @(negedge clk) begin
        if (chk_on) begin
            e_dv = 1'b0;
            e_pe = 1'b0;
            e_se = 1'b0;
            if (rst_q) begin
                model_pdata = '0;
                exp_q.delete();
            end else if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                e_dv = exp_q[0].dv;
                e_pe = exp_q[0].pe;
                e_se = exp_q[0].se;
                if (exp_q[0].dv) model_pdata = exp_q[0].data;
                void'(exp_q.pop_front());
            end
            check_val("DATA_VALID",   DW'(dv),   DW'(e_dv));
            check_val("PARITY_ERROR", DW'(perr), DW'(e_pe));
            check_val("STOP_ERROR",   DW'(serr), DW'(e_se));
            check_val("P_DATA",       p_data,    model_pdata);
            if (dv === 1'b1) begin
                dv_cyc_q.push_back(cyc);
                dv_dat_q.push_back(p_data);
            end
            if (perr === 1'b1) pe_seen++;
        end
    end

    // Hold the raw line at v for n cycles (called just after a rising edge).
    task automatic drive_bit(input logic v, input int n);
        rx_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Send one frame and register its expected outcome.
    task automatic send_frame(input logic [DW-1:0] data, input logic pe_en, input logic odd,
                              input logic flip, input logic stop_bad, input int gap_bits,
                              output int e_cyc);
        exp_t e;
        logic par;
        int   nbits;
        pen   = pe_en;
        ptype = odd;
        e_cyc = cyc;
        par   = (^data) ^ odd ^ flip;
        nbits = 1 + DW + (pe_en ? 1 : 0);
        // raw edge +2 synchroniser, stop sample at s + nbits*OS + OS/2 - 1, pulse one later
        e.at   = e_cyc + 2 + nbits * OS + OS / 2 + LAG;
        e.pe   = pe_en & flip;
        e.se   = stop_bad;
        e.dv   = !(pe_en & flip) && !stop_bad;
        e.data = data;
        exp_q.push_back(e);
        drive_bit(1'b0, OS);
        // configuration changes mid-frame must have no effect
        pen   = 1'($urandom);
        ptype = 1'($urandom);
        for (int i = 0; i < DW; i++) drive_bit(data[i], OS);
        if (pe_en) drive_bit(par, OS);
        if (stop_bad) begin
            // low through the whole sampling window, then back to idle
            drive_bit(1'b0, OS / 2 + 2);
            drive_bit(1'b1, OS / 2 - 2);
        end else begin
            drive_bit(1'b1, OS);
        end
        drive_bit(1'b1, gap_bits * OS);
    endtask

    int e0, e1, e2;
    logic [DW-1:0] rd;
    logic          rpe, rodd, rflip, rstop;
    int            rgap;

    initial begin
        rst   = 1'b1;
        rx_in = 1'b1;
        pen   = 1'b0;
        ptype = 1'b0;
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        drive_bit(1'b1, 2 * OS);

        // 0xA5, no parity: pulse at s+76, s = raw edge + 2
        dv_cyc_q.delete(); dv_dat_q.delete();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1, e0);
        check_int("a5_pulses", dv_cyc_q.size(), 1);
        if (dv_cyc_q.size() == 1) begin
            check_int("a5_latency", dv_cyc_q[0] - e0, 78 + LAG);
            check_val("a5_data", dv_dat_q[0], 8'hA5);
        end

        // even parity, 0x3C, correct parity bit 0
        dv_cyc_q.delete(); dv_dat_q.delete();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1, e0);
        check_int("par_ok_pulses", dv_cyc_q.size(), 1);
        if (dv_cyc_q.size() == 1) check_val("par_ok_data", dv_dat_q[0], 8'h3C);

        // same frame with parity bit 1: error only, P_DATA kept
        dv_cyc_q.delete(); pe_seen = 0;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1, e0);
        check_int("par_bad_dv", dv_cyc_q.size(), 0);
        check_int("par_bad_pe", pe_seen, 1);
        check_val("par_bad_keep", p_data, 8'h3C);

        // 0x81 with stop bit 0
        dv_cyc_q.delete();
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1, e0);
        check_int("stop_bad_dv", dv_cyc_q.size(), 0);
        check_val("stop_bad_keep", p_data, 8'h3C);

        // 2-cycle glitch, then 0x55
        dv_cyc_q.delete(); dv_dat_q.delete();
        drive_bit(1'b0, 2);
        drive_bit(1'b1, 3 * OS);
        check_int("glitch_dv", dv_cyc_q.size(), 0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1, e0);
        check_int("g55_pulses", dv_cyc_q.size(), 1);
        if (dv_cyc_q.size() == 1) check_val("g55_data", dv_dat_q[0], 8'h55);

        // back-to-back 0x12, 0x34
        dv_cyc_q.delete(); dv_dat_q.delete();
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 0, e1);
        send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1, e2);
        check_int("b2b_pulses", dv_cyc_q.size(), 2);
        if (dv_cyc_q.size() == 2) begin
            check_int("b2b_spacing", dv_cyc_q[1] - dv_cyc_q[0], 10 * OS);
            check_val("b2b_first", dv_dat_q[0], 8'h12);
            check_val("b2b_second", dv_dat_q[1], 8'h34);
        end

        // reset in the middle of 0xFF data bits, then 0x0F
        dv_cyc_q.delete(); dv_dat_q.delete();
        pen = 1'b0;
        drive_bit(1'b0, OS);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, OS);
        drive_bit(1'b1, 3);
        rst   = 1'b1;
        rx_in = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive_bit(1'b1, 2 * OS);
        check_int("abort_dv", dv_cyc_q.size(), 0);
        check_val("abort_pdata", p_data, 8'h00);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1, e0);
        check_int("after_rst_pulses", dv_cyc_q.size(), 1);
        if (dv_cyc_q.size() == 1) check_val("after_rst_data", dv_dat_q[0], 8'h0F);

        // randomized frames
        for (int n = 0; n < 60; n++) begin
            rd    = DW'($urandom);
            rpe   = 1'($urandom);
            rodd  = 1'($urandom);
            rflip = ($urandom_range(0, 7) == 0);
            rstop = ($urandom_range(0, 7) == 0);
            rgap  = rstop ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
            send_frame(rd, rpe, rodd, rflip, rstop, rgap, e0);
        end

        drive_bit(1'b1, 4 * OS);
        check_int("pending_expectations", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
